// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: default token width, FIFO depth limit and the elastic channel type.
package cgra_pkg;

  localparam int unsigned CGRA_DATA_WIDTH = 32;
  localparam int unsigned FIFO_MAX_DEPTH  = 16;

  typedef struct packed {
    logic [CGRA_DATA_WIDTH-1:0] data;
    logic                       valid;
  } elastic_ch_t;

  // Slot-index width; a one-slot store still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH token store: one synchronous write port, one asynchronous read port.
module fifo_regfile
  import cgra_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CGRA_DATA_WIDTH,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned AW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately left unreset; occupancy lives in the controller.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_fifo.sv
// Elastic valid/ready buffer behind a CGRA input mux; in-order, registered, count-tracked.
// Optional zero-latency empty bypass is enabled by defining ELASTIC_FIFO_BYPASS_EN.
module elastic_fifo
  import cgra_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CGRA_DATA_WIDTH,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  passthru;
  logic                  wr_en;
  logic                  rd_adv;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Handshake: a token moves on a side only in a cycle where both valid and ready
  // are high there (push = valid_i & ready_o, pop = valid_o & ready_i). ready_o is
  // a function of stored state only, so ready_i never reaches ready_o.
  assign ready_o = !full;

`ifdef ELASTIC_FIFO_BYPASS_EN
  assign valid_o  = !empty || valid_i;
  assign data_o   = !empty ? rdata : (valid_i ? data_i : '0);
  assign passthru = empty && valid_i && ready_i;
`else
  assign valid_o  = !empty;
  assign data_o   = !empty ? rdata : '0;
  assign passthru = 1'b0;
`endif

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  // A passed-through token touches neither the store nor the pointers.
  assign wr_en  = push && !passthru && !clr_i;
  assign rd_adv = pop && !passthru;

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_regfile (
    .clk   (clk_i),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: three depths (2, 3, 4) checked against a queue-based reference.
module tb_elastic_fifo;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clr;
  logic [DW-1:0] data_in;
  logic          valid_in [3];
  logic          ready_in [3];

  logic [DW-1:0] dout0, dout1, dout2;
  logic          vout0, vout1, vout2;
  logic          rout0, rout1, rout2;
  logic [1:0]    cnt0;
  logic [1:0]    cnt1;
  logic [2:0]    cnt2;

  elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .data_i(data_in), .valid_i(valid_in[0]),
    .ready_o(rout0), .data_o(dout0), .valid_o(vout0), .ready_i(ready_in[0]), .count_o(cnt0)
  );
  elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .data_i(data_in), .valid_i(valid_in[1]),
    .ready_o(rout1), .data_o(dout1), .valid_o(vout1), .ready_i(ready_in[1]), .count_o(cnt1)
  );
  elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .data_i(data_in), .valid_i(valid_in[2]),
    .ready_o(rout2), .data_o(dout2), .valid_o(vout2), .ready_i(ready_in[2]), .count_o(cnt2)
  );

  int            cur;
  logic [DW-1:0] obs_data;
  logic          obs_valid;
  logic          obs_ready;
  logic [4:0]    obs_cnt;

  always_comb begin
    obs_data  = dout0;
    obs_valid = vout0;
    obs_ready = rout0;
    obs_cnt   = {3'b000, cnt0};
    case (cur)
      1: begin obs_data = dout1; obs_valid = vout1; obs_ready = rout1; obs_cnt = {3'b000, cnt1}; end
      2: begin obs_data = dout2; obs_valid = vout2; obs_ready = rout2; obs_cnt = {2'b00, cnt2}; end
      default: ;
    endcase
  end

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_ready;
  logic [4:0]    exp_cnt;

  function automatic int depth_of(input int k);
    return k + 2;
  endfunction

  // Drive one cycle's inputs after the falling edge, then derive expected outputs from the queue.
  task automatic step(input logic r_n, input logic v, input logic [DW-1:0] d,
                      input logic rdy, input logic c);
    int sz;
    @(negedge clk);
    rst_n = r_n; clr = c; data_in = d;
    valid_in[cur] = v; ready_in[cur] = rdy;
    #1;
    sz = exp_q.size();
    exp_cnt   = 5'(sz);
    exp_ready = (sz != depth_of(cur));
    exp_valid = (sz != 0);
    exp_data  = (sz != 0) ? exp_q[0] : '0;
`ifdef ELASTIC_FIFO_BYPASS_EN
    if (sz == 0 && v) begin exp_valid = 1'b1; exp_data = d; end
`endif
  endtask

  // Advance one rising edge and apply the transfer rules to the reference queue.
  task automatic adv();
    int sz;
    logic push, pop, thru;
    logic [DW-1:0] tmp;
    sz   = exp_q.size();
    push = valid_in[cur] && (sz != depth_of(cur));
    pop  = (sz != 0) && ready_in[cur];
    thru = 1'b0;
`ifdef ELASTIC_FIFO_BYPASS_EN
    thru = (sz == 0) && valid_in[cur] && ready_in[cur];
`endif
    @(posedge clk);
    if (!rst_n || clr) exp_q.delete();
    else if (!thru) begin
      if (pop) tmp = exp_q.pop_front();
      if (push) exp_q.push_back(data_in);
    end
  endtask

  task automatic reset_all();
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin valid_in[j] = 1'b0; ready_in[j] = 1'b0; end
    repeat (2) begin step(1'b0, 1'b0, '0, 1'b0, 1'b0); adv(); end
  endtask

  task automatic test_reset();
    cur = 0;
    reset_all();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", obs_ready); end
    checks++; if (obs_cnt !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", obs_cnt); end
    checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", obs_data); end
    checks++; if (cnt2 !== 3'd0 || vout2 !== 1'b0) begin errors++; $display("FAIL reset_d4: got cnt=%0d valid=%b want 0/0", cnt2, vout2); end
    adv();
  endtask

  task automatic test_full_hold();
    logic [DW-1:0] got[$];
    logic [DW-1:0] want [3];
    logic pend;
    want[0] = 32'hA5; want[1] = 32'h5A; want[2] = 32'h77;
    cur = 0;
    reset_all();
    step(1'b1, 1'b1, 32'hA5, 1'b0, 1'b0); adv();
    step(1'b1, 1'b1, 32'h5A, 1'b0, 1'b0); adv();
    step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    checks++; if (obs_cnt !== 5'd2) begin errors++; $display("FAIL full_count: got %0d want 2", obs_cnt); end
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", obs_ready); end
    adv();
    pend = 1'b1;
    for (int cyc = 0; cyc < 10 && got.size() < 3; cyc++) begin
      step(1'b1, pend, 32'h77, 1'b1, 1'b0);
      if (obs_valid === 1'b1) got.push_back(obs_data);
      if (pend && exp_ready) pend = 1'b0;
      adv();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL full_drain_len: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL full_drain_%0d: got %h want %h", i, got[i], want[i]); end
    end
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL full_no_dup: got valid %b want 0", obs_valid); end
    adv();
  endtask

  task automatic test_streaming();
    int tok, emitted;
    cur = 2;
    reset_all();
    tok = 0; emitted = 0;
    for (int cyc = 0; cyc < 110 && emitted < 100; cyc++) begin
      step(1'b1, tok < 100, DW'(tok), 1'b1, 1'b0);
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, obs_valid, exp_valid); end
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL stream_count c%0d: got %0d want %0d", cyc, obs_cnt, exp_cnt); end
      if (obs_valid === 1'b1) begin
        checks++; if (obs_data !== DW'(emitted)) begin errors++; $display("FAIL stream_order: got %0d want %0d", obs_data, emitted); end
        emitted++;
      end
      if (tok < 100 && exp_ready) tok++;
      adv();
    end
    checks++; if (emitted != 100) begin errors++; $display("FAIL stream_total: got %0d want 100", emitted); end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] want [3];
    want[0] = 32'd2; want[1] = 32'd3; want[2] = 32'd4;
    cur = 1;
    reset_all();
    for (int i = 1; i <= 3; i++) begin step(1'b1, 1'b1, DW'(i), 1'b0, 1'b0); adv(); end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (obs_cnt !== 5'd3 || obs_ready !== 1'b0) begin errors++; $display("FAIL simul_full: got cnt=%0d ready=%b want 3/0", obs_cnt, obs_ready); end
    adv();
    step(1'b1, 1'b1, 32'd4, 1'b1, 1'b0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL simul_ready_held: got %b want 0", obs_ready); end
    checks++; if (obs_data !== 32'd1 || obs_valid !== 1'b1) begin errors++; $display("FAIL simul_head: got %0d/%b want 1/1", obs_data, obs_valid); end
    adv();
    step(1'b1, 1'b1, 32'd4, 1'b0, 1'b0);
    checks++; if (obs_ready !== 1'b1 || obs_cnt !== 5'd2) begin errors++; $display("FAIL simul_freed: got ready=%b cnt=%0d want 1/2", obs_ready, obs_cnt); end
    adv();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (obs_cnt !== 5'd3) begin errors++; $display("FAIL simul_refill: got %0d want 3", obs_cnt); end
    adv();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (obs_data !== want[i]) begin errors++; $display("FAIL simul_drain_%0d: got %0d want %0d", i, obs_data, want[i]); end
      adv();
    end
  endtask

  task automatic test_flush();
    cur = 2;
    reset_all();
    for (int i = 1; i <= 3; i++) begin step(1'b1, 1'b1, DW'(i * 17), 1'b0, 1'b0); adv(); end
    step(1'b1, 1'b1, 32'h99, 1'b0, 1'b1); adv();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (obs_cnt !== 5'd0 || obs_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got cnt=%0d valid=%b want 0/0", obs_cnt, obs_valid); end
    adv();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got valid %b data %h want 0", obs_valid, obs_data); end
      adv();
    end
  endtask

  task automatic test_bypass();
    cur = 2;
    reset_all();
    step(1'b1, 1'b1, 32'h3C, 1'b1, 1'b0);
`ifdef ELASTIC_FIFO_BYPASS_EN
    checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h3C) begin errors++; $display("FAIL bypass_same_cycle: got %b/%h want 1/3c", obs_valid, obs_data); end
    adv();
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (obs_cnt !== 5'd0 || obs_valid !== 1'b0) begin errors++; $display("FAIL bypass_not_stored: got cnt=%0d valid=%b want 0/0", obs_cnt, obs_valid); end
`else
    checks++; if (obs_valid !== 1'b0 || obs_data !== 32'h0) begin errors++; $display("FAIL latency_first: got %b/%h want 0/0", obs_valid, obs_data); end
    adv();
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h3C || obs_cnt !== 5'd1) begin errors++; $display("FAIL latency_next: got %b/%h/%0d want 1/3c/1", obs_valid, obs_data, obs_cnt); end
`endif
    adv();
  endtask

  task automatic test_random(input int k, input int n);
    cur = k;
    reset_all();
    for (int i = 0; i < n; i++) begin
      logic r_n, v, rdy, c;
      logic [DW-1:0] d;
      r_n = ($urandom_range(0, 149) != 0);
      c   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ((i / 30) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      d   = $urandom;
      step(r_n, v, d, rdy, c);
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rand_valid d%0d i%0d: got %b want %b", k + 2, i, obs_valid, exp_valid); end
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready d%0d i%0d: got %b want %b", k + 2, i, obs_ready, exp_ready); end
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL rand_count d%0d i%0d: got %0d want %0d", k + 2, i, obs_cnt, exp_cnt); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rand_data d%0d i%0d: got %h want %h", k + 2, i, obs_data, exp_data); end
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; data_in = '0; cur = 0;
    for (int j = 0; j < 3; j++) begin valid_in[j] = 1'b0; ready_in[j] = 1'b0; end
    test_reset();
    test_full_hold();
    test_streaming();
    test_full_simul();
    test_flush();
    test_bypass();
    for (int k = 0; k < 3; k++) test_random(k, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_fifo.md
Name: elastic_fifo

Overview:
- Elastic valid/ready buffer placed directly downstream of each PE/interconnect input multiplexer in the CGRA.
- Captures the selected operand stream from the mux and decouples producer from consumer.
- Absorbs backpressure so one stalled PE does not immediately freeze its upstream neighbours.
- Registered storage; in-order; no data modification.

Parameters:
DATA_WIDTH  32  width of one data token
DEPTH  2  number of token slots; legal range 2..16, need not be a power of two

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  synchronous active-low reset
clr_i  input  1  synchronous flush (used on reconfiguration), active-high
data_i  input  DATA_WIDTH  token from upstream mux output
valid_i  input  1  upstream token valid
ready_o  output  1  buffer can accept a token
data_o  output  DATA_WIDTH  head token
valid_o  output  1  head token valid
ready_i  input  1  downstream accepts head token
count_o  output  $clog2(DEPTH+1)  occupied slots

Behaviour:
- Reset: rst_ni low at a rising edge gives count=0 and rd_ptr=wr_ptr=0. Outputs after that edge: valid_o=0, ready_o=1, count_o=0, data_o='0. Storage array is not reset.
- push = valid_i && ready_o; pop = valid_o && ready_i.
- ready_o = (count != DEPTH). It is purely state-derived, with no combinational path from ready_i.
- valid_o = (count != 0).
- data_o = mem[rd_ptr] when count != 0, else '0.
- Latency: a token pushed in cycle N is visible on data_o/valid_o in cycle N+1 at the earliest.
- Push writes mem[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop advances rd_ptr with the same wrap rule.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count=DEPTH): ready_o=0 and the upstream token is held, not lost. Pop in the same cycle is allowed and frees a slot for the next cycle only.
- Empty (count=0): valid_o=0, so a same-cycle push and pop is impossible. The push lands, and the token appears next cycle.
- Push and pop together at 0<count<DEPTH: count is unchanged and both pointers advance.
- Pointer comparison: full/empty are determined by count, not by pointer equality.
- clr_i=1: same effect as reset on count and pointers. It has priority over push/pop in that cycle, and any token offered during clr_i is dropped.
- Reset has priority over clr_i.
- Reset mid-stream: all buffered tokens are discarded. No output glitch beyond the defined reset values.

Optional Feature:
- Macro: ELASTIC_FIFO_BYPASS_EN.
- Defined: when count=0 and valid_i=1, valid_o=1 and data_o=data_i in the same cycle (zero latency).
  - If ready_i=1 as well, the token passes through, is not written, and count stays 0.
  - If ready_i=0, the token is written normally.
  - ready_o is still state-only, so no ready_i -> ready_o path exists.
- Undefined: behaviour exactly as above, with a minimum latency of one cycle.

Decomposition:
- Shared package cgra_pkg:
  - DATA_WIDTH default constant.
  - Max FIFO depth constant (16).
  - Elastic channel typedef: struct of data, valid.
- One natural sub-module: fifo_regfile.
  - DEPTH x DATA_WIDTH storage with one write port (we, waddr, wdata) and one asynchronous read port.
  - Pointer/count control stays in elastic_fifo.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, then 1 -> valid_o=0, ready_o=1, count_o=0, data_o=0.
- DEPTH=2, ready_i=0, push 0xA5, 0x5A -> count_o=2, ready_o=0. A third offer of 0x77 is held upstream. Raise ready_i -> outputs 0xA5, 0x5A, 0x77 in order, with no duplicates or drops.
- Streaming: DEPTH=4, valid_i=ready_i=1 continuously, data 0..99.
  - Default build: one bubble at start, then 1 token/cycle, count_o steady at 1, data in order.
  - Pointer wrap checked past index 3.
- Simultaneous at full: DEPTH=3, full with 1,2,3. One cycle with ready_i=1 and valid_i=1 carrying 4 -> 1 popped and 4 not accepted (ready_o=0). Next cycle 4 is accepted, ending at count_o=3.
- Flush: 3 tokens buffered, clr_i=1 for one cycle with valid_i=1, data 0x99 -> next cycle count_o=0, valid_o=0, and 0x99 is never emitted.
- ELASTIC_FIFO_BYPASS_EN build: empty buffer, valid_i=1, data 0x3C, ready_i=1 -> valid_o=1, data_o=0x3C in the same cycle, and count_o stays 0.
